// File: rtl/ps2_scancode_fifo.sv
// rtl/ps2_scancode_fifo.sv - PS/2 set-2 byte stream to key-event decoder with show-ahead event FIFO
// Folds E0/F0 prefixes into {ext, rel, ascii, code} events and tracks the last ASCII make key.
module ps2_scancode_fifo #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3,
  parameter int DROP_RELEASE = 0,
  parameter int TRANSLATE    = 1
) (
  input  logic              inclock,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              ev_rd,
  input  logic              ovf_clr,
  output logic              ev_valid,
  output logic [17:0]       ev_data,
  output logic [ADDR_W:0]   ev_count,
  output logic              ovf,
  output logic [7:0]        last_key
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          last_key_q, last_key_d;
  logic [17:0]         mem_q [FIFO_DEPTH];

  logic                is_ctrl, emit, emit_ext, emit_rel;
  logic                push_req, push, pop, full, drop;
  logic [7:0]          ascii;
  logic [17:0]         wr_data;

  function automatic logic [7:0] map_ascii(input logic [7:0] code);
    case (code)
      8'h1C: map_ascii = 8'h41;  8'h32: map_ascii = 8'h42;  8'h21: map_ascii = 8'h43;
      8'h23: map_ascii = 8'h44;  8'h24: map_ascii = 8'h45;  8'h2B: map_ascii = 8'h46;
      8'h34: map_ascii = 8'h47;  8'h33: map_ascii = 8'h48;  8'h43: map_ascii = 8'h49;
      8'h3B: map_ascii = 8'h4A;  8'h42: map_ascii = 8'h4B;  8'h4B: map_ascii = 8'h4C;
      8'h3A: map_ascii = 8'h4D;  8'h31: map_ascii = 8'h4E;  8'h44: map_ascii = 8'h4F;
      8'h4D: map_ascii = 8'h50;  8'h15: map_ascii = 8'h51;  8'h2D: map_ascii = 8'h52;
      8'h1B: map_ascii = 8'h53;  8'h2C: map_ascii = 8'h54;  8'h3C: map_ascii = 8'h55;
      8'h2A: map_ascii = 8'h56;  8'h1D: map_ascii = 8'h57;  8'h22: map_ascii = 8'h58;
      8'h35: map_ascii = 8'h59;  8'h1A: map_ascii = 8'h5A;
      8'h45: map_ascii = 8'h30;  8'h16: map_ascii = 8'h31;  8'h1E: map_ascii = 8'h32;
      8'h26: map_ascii = 8'h33;  8'h25: map_ascii = 8'h34;  8'h2E: map_ascii = 8'h35;
      8'h36: map_ascii = 8'h36;  8'h3D: map_ascii = 8'h37;  8'h3E: map_ascii = 8'h38;
      8'h46: map_ascii = 8'h39;
      8'h29: map_ascii = 8'h20;  8'h5A: map_ascii = 8'h0D;  8'h66: map_ascii = 8'h08;
      default: map_ascii = 8'h00;
    endcase
  endfunction

  // Keyboard acks, BAT results, errors and the Pause prefix abort any partial sequence.
  assign is_ctrl = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                   (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF) ||
                   (rx_data == 8'hE1);

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_rel = 1'b0;
    if (rx_valid) begin
      if (is_ctrl) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_data == 8'hE0)      state_d = EXT;
            else if (rx_data == 8'hF0) state_d = BRK;
            else                       emit = 1'b1;
          end
          EXT: begin
            if (rx_data == 8'hF0)      state_d = EXT_BRK;
            else if (rx_data != 8'hE0) begin
              emit = 1'b1; emit_ext = 1'b1; state_d = IDLE;
            end
          end
          BRK: begin
            if (rx_data == 8'hE0)      state_d = EXT_BRK;
            else if (rx_data != 8'hF0) begin
              emit = 1'b1; emit_rel = 1'b1; state_d = IDLE;
            end
          end
          default: begin
            if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
              emit = 1'b1; emit_ext = 1'b1; emit_rel = 1'b1; state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    ascii      = 8'h00;
    if (TRANSLATE != 0 && !emit_ext) ascii = map_ascii(rx_data);
    wr_data    = {emit_ext, emit_rel, ascii, rx_data};
    push_req   = emit && !(emit_rel && DROP_RELEASE != 0);
    full       = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
    pop        = ev_rd && (count_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;

    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_W+1)'(1);

    ovf_d      = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    last_key_d = last_key_q;
    if (emit && !emit_rel && ascii != 8'h00) last_key_d = ascii;
  end

  always_ff @(posedge inclock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      last_key_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      last_key_q <= last_key_d;
    end
  end

  always_ff @(posedge inclock) begin
    if (resetn && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign ev_valid = (count_q != '0);
  assign ev_data  = mem_q[rd_ptr_q];
  assign ev_count = count_q;
  assign ovf      = ovf_q;
  assign last_key = last_key_q;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// tb/tb_ps2_scancode_fifo.sv - scoreboard bench for ps2_scancode_fifo (depth 4)
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          inclock = 1'b0;
  logic          resetn  = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          ev_rd   = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          ev_valid;
  logic [17:0]   ev_data;
  logic [AW:0]   ev_count;
  logic          ovf;
  logic [7:0]    last_key;

  int            checks   = 0;
  int            failures = 0;

  logic [17:0]   sbq[$];
  int            m_state = 0;
  logic          m_ovf   = 1'b0;
  logic [7:0]    m_last  = 8'h00;

  ps2_scancode_fifo #(
    .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DROP_RELEASE(0), .TRANSLATE(1)
  ) dut (
    .inclock(inclock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_rd(ev_rd), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_data(ev_data),
    .ev_count(ev_count), .ovf(ovf), .last_key(last_key)
  );

  always #10 inclock = ~inclock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c);
    case (c)
      8'h1C: return "A"; 8'h32: return "B"; 8'h21: return "C"; 8'h23: return "D";
      8'h24: return "E"; 8'h2B: return "F"; 8'h34: return "G"; 8'h33: return "H";
      8'h43: return "I"; 8'h3B: return "J"; 8'h42: return "K"; 8'h4B: return "L";
      8'h3A: return "M"; 8'h31: return "N"; 8'h44: return "O"; 8'h4D: return "P";
      8'h15: return "Q"; 8'h2D: return "R"; 8'h1B: return "S"; 8'h2C: return "T";
      8'h3C: return "U"; 8'h2A: return "V"; 8'h1D: return "W"; 8'h22: return "X";
      8'h35: return "Y"; 8'h1A: return "Z";
      8'h45: return "0"; 8'h16: return "1"; 8'h1E: return "2"; 8'h26: return "3";
      8'h25: return "4"; 8'h2E: return "5"; 8'h36: return "6"; 8'h3D: return "7";
      8'h3E: return "8"; 8'h46: return "9";
      8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_outputs();
    chk("ev_valid", 32'(ev_valid), 32'(sbq.size() != 0));
    chk("ev_count", 32'(ev_count), 32'(sbq.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("last_key", 32'(last_key), 32'(m_last));
    if (sbq.size() != 0) chk("head", 32'(ev_data), 32'(sbq[0]));
  endtask

  // One clock: drive inputs, advance the reference model, check everything after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic rd, input logic clr);
    int         sz;
    logic       pop, emit, ext, rel;
    logic [7:0] a;
    @(negedge inclock);
    rx_valid = v; rx_data = b; ev_rd = rd; ovf_clr = clr;
    sz  = sbq.size();
    pop = rd && (sz > 0);
    if (pop) chk("pop_data", 32'(ev_data), 32'(sbq[0]));
    emit = 1'b0; ext = 1'b0; rel = 1'b0;
    if (v) begin
      if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1}) m_state = 0;
      else case (m_state)
        0: if (b == 8'hE0) m_state = 1; else if (b == 8'hF0) m_state = 2; else emit = 1'b1;
        1: if (b == 8'hF0) m_state = 3; else if (b != 8'hE0) begin emit = 1'b1; ext = 1'b1; m_state = 0; end
        2: if (b == 8'hE0) m_state = 3; else if (b != 8'hF0) begin emit = 1'b1; rel = 1'b1; m_state = 0; end
        default: if (b != 8'hE0 && b != 8'hF0) begin emit = 1'b1; ext = 1'b1; rel = 1'b1; m_state = 0; end
      endcase
    end
    @(posedge inclock);
    #1;
    if (pop) void'(sbq.pop_front());
    if (clr) m_ovf = 1'b0;
    if (emit) begin
      a = ext ? 8'h00 : ref_ascii(b);
      if (!rel && a != 8'h00) m_last = a;
      if (sz < DEPTH || pop) sbq.push_back({ext, rel, a, b});
      else m_ovf = 1'b1;
    end
    rx_valid = 1'b0; ev_rd = 1'b0; ovf_clr = 1'b0;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic drain();
    while (sbq.size() > 0) pop_one();
  endtask

  task automatic do_reset();
    @(negedge inclock);
    resetn = 1'b0; rx_valid = 1'b0; ev_rd = 1'b0; ovf_clr = 1'b0;
    @(posedge inclock);
    #1;
    resetn = 1'b1;
    sbq.delete(); m_state = 0; m_ovf = 1'b0; m_last = 8'h00;
    check_outputs();
  endtask

  initial begin
    do_reset();

    // T1: single make, one-cycle latency, translated
    send(8'h1C);
    chk("t1_event", 32'(ev_data), 32'({1'b0, 1'b0, 8'h41, 8'h1C}));
    drain();

    // T2: break keeps last_key
    send(8'h32);
    drain();
    send(8'hF0); send(8'h1C);
    chk("t2_event", 32'(ev_data), 32'({1'b0, 1'b1, 8'h41, 8'h1C}));
    chk("t2_last", 32'(last_key), 32'h42);
    drain();

    // T3: prefix combinations and control-byte aborts
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hE0); send(8'h75);
    send(8'hFA); send(8'h32);
    send(8'hE0); send(8'hFA); send(8'h32);
    drain();
    send(8'hF0); send(8'hE0); send(8'h6B);
    send(8'hF0); send(8'hAA); send(8'h45);
    send(8'h46); send(8'h29);
    drain();
    send(8'h5A); send(8'h66); send(8'h0E); send(8'hE0); send(8'h1C);
    drain();

    // T4: overflow, then pop+push while full
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("t4_count", 32'(ev_count), 32'd4);
    chk("t4_ovf", 32'(ovf), 32'd1);
    step(1'b1, 8'h35, 1'b1, 1'b0);
    chk("t4_keep_count", 32'(ev_count), 32'd4);

    // T6: overflow beats ovf_clr; dropped make still updates last_key
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    chk("t6_ovf_prio", 32'(ovf), 32'd1);
    chk("t6_last_drop", 32'(last_key), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_ovf_clr", 32'(ovf), 32'd0);
    drain();

    // T6: pop while empty
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_empty_count", 32'(ev_count), 32'd0);

    // T5: reset mid-sequence discards E0 F0
    send(8'h1A);
    send(8'hE0); send(8'hF0);
    do_reset();
    chk("t5_last_rst", 32'(last_key), 32'd0);
    send(8'h32);
    chk("t5_event", 32'(ev_data), 32'({1'b0, 1'b0, 8'h42, 8'h32}));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
